spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 148 ++++++++++++++
 tb/tb_spi_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// ============================================================================
// Module      : spi_master
// Description : Mode-0 SPI master; WIDTH-bit MSB-first transfers, CLKDIV clk
//               cycles per SCLK half-period, lead/trail select guard times.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master #(
    parameter int WIDTH  = 8,
    parameter int CLKDIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             sclk,
    output logic             cs_n,
    output logic             mosi,
    input  logic             miso
);

    localparam int c_cw = $clog2(CLKDIV + 1);
    localparam int c_bw = $clog2(WIDTH + 1);
    localparam logic [c_cw-1:0] c_cnt_load = c_cw'(CLKDIV - 1);
    localparam logic [c_bw-1:0] c_last_bit = c_bw'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_LOW   = 3'd2,
        S_HIGH  = 3'd3,
        S_TRAIL = 3'd4
    } state_t;

    state_t           r_state;
    logic [c_cw-1:0]  r_cnt;
    logic [c_bw-1:0]  r_bits;
    logic [WIDTH-1:0] r_tx_sh;
    logic [WIDTH-1:0] r_rx_sh;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_busy;
    logic             r_done;
    logic             r_sclk;
    logic             r_cs_n;
    logic             r_mosi;

    logic [WIDTH-1:0] w_tx_next;
    logic [WIDTH-1:0] w_rx_next;
    logic             w_cnt_zero;

    // Concatenate-then-truncate keeps both shifts legal even for WIDTH=1.
    assign w_tx_next  = WIDTH'({r_tx_sh, 1'b0});
    assign w_rx_next  = WIDTH'({r_rx_sh, miso});
    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bits    <= '0;
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_rx_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_mosi    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LEAD;
                        r_tx_sh <= tx_data;
                        r_rx_sh <= '0;
                        r_cnt   <= c_cnt_load;
                        r_bits  <= '0;
                        r_busy  <= 1'b1;
                        r_cs_n  <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_mosi  <= tx_data[WIDTH-1];
                    end
                end
                S_LEAD, S_LOW: begin
                    if (w_cnt_zero) begin
                        r_state <= S_HIGH;
                        r_cnt   <= c_cnt_load;
                        r_sclk  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HIGH: begin
                    if (w_cnt_zero) begin
                        // Falling SCLK edge: sample miso, then present the next bit.
                        r_rx_sh <= w_rx_next;
                        r_bits  <= r_bits + 1'b1;
                        r_cnt   <= c_cnt_load;
                        r_sclk  <= 1'b0;
                        if (r_bits == c_last_bit) begin
                            r_state <= S_TRAIL;
                        end else begin
                            r_state <= S_LOW;
                            r_tx_sh <= w_tx_next;
                            r_mosi  <= w_tx_next[WIDTH-1];
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_TRAIL: begin
                    if (w_cnt_zero) begin
                        r_state   <= S_IDLE;
                        r_rx_data <= r_rx_sh;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_cs_n    <= 1'b1;
                        r_mosi    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cs_n  <= 1'b1;
                    r_sclk  <= 1'b0;
                    r_mosi  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign sclk    = r_sclk;
    assign cs_n    = r_cs_n;
    assign mosi    = r_mosi;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// Module      : tb_spi_master
// Description : Self-checking bench for spi_master at CLKDIV 2, 4 and 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [1:0] sel;
        logic       mode;   // 0: loopback, 1: slave model
        logic [7:0] tx;
        logic [7:0] slv;
        logic [7:0] rx;
        int         cyc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] tx_data;
    logic [1:0] sel;
    logic       mode;
    logic [7:0] slv_word;
    logic [7:0] slv_sh;

    logic       busy_a [3];
    logic       done_a [3];
    logic [7:0] rx_a   [3];
    logic       sclk_a [3];
    logic       cs_n_a [3];
    logic       mosi_a [3];

    logic       busy_m, done_m, sclk_m, cs_n_m, mosi_m;
    logic [7:0] rx_m;
    wire        miso_w;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    spi_master #(.WIDTH(8), .CLKDIV(2)) u_div2 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2'd0), .tx_data(tx_data),
        .busy(busy_a[0]), .done(done_a[0]), .rx_data(rx_a[0]),
        .sclk(sclk_a[0]), .cs_n(cs_n_a[0]), .mosi(mosi_a[0]), .miso(miso_w));

    spi_master #(.WIDTH(8), .CLKDIV(4)) u_div4 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2'd1), .tx_data(tx_data),
        .busy(busy_a[1]), .done(done_a[1]), .rx_data(rx_a[1]),
        .sclk(sclk_a[1]), .cs_n(cs_n_a[1]), .mosi(mosi_a[1]), .miso(miso_w));

    spi_master #(.WIDTH(8), .CLKDIV(1)) u_div1 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2'd2), .tx_data(tx_data),
        .busy(busy_a[2]), .done(done_a[2]), .rx_data(rx_a[2]),
        .sclk(sclk_a[2]), .cs_n(cs_n_a[2]), .mosi(mosi_a[2]), .miso(miso_w));

    assign busy_m = busy_a[sel];
    assign done_m = done_a[sel];
    assign rx_m   = rx_a[sel];
    assign sclk_m = sclk_a[sel];
    assign cs_n_m = cs_n_a[sel];
    assign mosi_m = mosi_a[sel];

    // Slave drives only while selected and releases the line otherwise.
    assign miso_w = (mode == 1'b0) ? mosi_m : (cs_n_m ? 1'bz : slv_sh[7]);

    always @(negedge cs_n_m) slv_sh = slv_word;
    always @(negedge sclk_m) if (!cs_n_m) slv_sh = slv_sh << 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard consumer ----------------
    int   rises, busy_cnt, cs_cnt, hi_run, last_gap, n_done;
    logic sclk_prev, done_prev, x_seen;
    logic [7:0] cur_tx;
    exp_t e;

    initial begin
        rises = 0; busy_cnt = 0; cs_cnt = 0; hi_run = 0; last_gap = 0; n_done = 0;
        sclk_prev = 1'b0; done_prev = 1'b0; x_seen = 1'b0; cur_tx = 8'h00;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            rises = 0; busy_cnt = 0; cs_cnt = 0; hi_run = 0;
            sclk_prev = 1'b0; done_prev = 1'b0;
        end else begin
            if ($isunknown({busy_m, done_m, rx_m, sclk_m, cs_n_m, mosi_m})) x_seen = 1'b1;
            if (sclk_m && !sclk_prev) begin
                chk("rise_cs_n_low", 32'(cs_n_m), 32'd0);
                if (sb.size() > 0 && rises < 8) begin
                    cur_tx = sb[0].tx;
                    chk("mosi_at_rise", 32'(mosi_m), 32'(cur_tx[7-rises]));
                end
                rises++;
            end
            if (done_m) begin
                n_done++;
                chk("done_width", 32'(done_prev), 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done_m), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rx_data", 32'(rx_m), 32'(e.rx));
                    chk("busy_cycles", 32'(busy_cnt), 32'(e.cyc));
                    chk("cs_low_cycles", 32'(cs_cnt), 32'(e.cyc));
                    chk("sclk_rises", 32'(rises), 32'd8);
                    chk("no_x_outputs", 32'(x_seen), 32'd0);
                end
                rises = 0; busy_cnt = 0; cs_cnt = 0;
            end
            if (busy_m) busy_cnt++;
            if (!cs_n_m) begin
                cs_cnt++;
                if (hi_run > 0) last_gap = hi_run;
                hi_run = 0;
            end else begin
                hi_run++;
            end
            sclk_prev = sclk_m;
            done_prev = done_m;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic run_txn(input logic [7:0] tx, input logic [7:0] rx, input int cyc);
        sb.push_back('{tx: tx, rx: rx, cyc: cyc});
        tx_data = tx;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy", 32'(busy_m), 32'd1);
        chk("accept_cs_n", 32'(cs_n_m), 32'd0);
        chk("accept_sclk", 32'(sclk_m), 32'd0);
        chk("accept_mosi", 32'(mosi_m), 32'(tx[7]));
    endtask

    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            chk("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic check_idle(input logic [7:0] rx);
        chk("idle_busy", 32'(busy_m), 32'd0);
        chk("idle_cs_n", 32'(cs_n_m), 32'd1);
        chk("idle_sclk", 32'(sclk_m), 32'd0);
        chk("idle_mosi", 32'(mosi_m), 32'd0);
        chk("idle_rx_hold", 32'(rx_m), 32'(rx));
    endtask

    vec_t vecs[7];
    int   d0;

    initial begin
        rst_n = 1'b0; start = 1'b0; tx_data = 8'h00;
        sel = 2'd0; mode = 1'b0; slv_word = 8'h00; slv_sh = 8'h00;

        vecs[0] = '{sel: 2'd0, mode: 1'b0, tx: 8'hA5, slv: 8'h00, rx: 8'hA5, cyc: 34};
        vecs[1] = '{sel: 2'd0, mode: 1'b0, tx: 8'h3C, slv: 8'h00, rx: 8'h3C, cyc: 34};
        vecs[2] = '{sel: 2'd1, mode: 1'b1, tx: 8'hFF, slv: 8'h3C, rx: 8'h3C, cyc: 68};
        vecs[3] = '{sel: 2'd2, mode: 1'b1, tx: 8'h00, slv: 8'h81, rx: 8'h81, cyc: 17};
        vecs[4] = '{sel: 2'd0, mode: 1'b1, tx: 8'hFF, slv: 8'h00, rx: 8'h00, cyc: 34};
        vecs[5] = '{sel: 2'd2, mode: 1'b0, tx: 8'h5A, slv: 8'h00, rx: 8'h5A, cyc: 17};
        vecs[6] = '{sel: 2'd1, mode: 1'b0, tx: 8'h01, slv: 8'h00, rx: 8'h01, cyc: 68};

        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            check_idle(8'h00);
            chk("reset_done", 32'(done_m), 32'd0);
        end
        sel = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven transactions
        for (int v = 0; v < 7; v++) begin
            sel = vecs[v].sel; mode = vecs[v].mode; slv_word = vecs[v].slv;
            @(negedge clk);
            run_txn(vecs[v].tx, vecs[v].rx, vecs[v].cyc);
            wait_empty(300);
            repeat (5) @(negedge clk);
            check_idle(vecs[v].rx);
        end

        // Second start 5 cycles into a transfer, with tx_data changed, is ignored
        sel = 2'd0; mode = 1'b0; d0 = n_done;
        @(negedge clk);
        run_txn(8'h96, 8'h96, 34);
        repeat (4) @(negedge clk);
        tx_data = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_empty(300);
        repeat (40) @(negedge clk);
        chk("single_done", 32'(n_done - d0), 32'd1);
        check_idle(8'h96);

        // Back-to-back with start held through done
        d0 = n_done;
        sb.push_back('{tx: 8'h12, rx: 8'h12, cyc: 34});
        sb.push_back('{tx: 8'h34, rx: 8'h34, cyc: 34});
        tx_data = 8'h12; start = 1'b1;
        @(negedge clk);
        tx_data = 8'h34;
        for (int i = 0; i < 100 && !done_m; i++) @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_second_accept", 32'(busy_m), 32'd1);
        wait_empty(300);
        chk("b2b_two_dones", 32'(n_done - d0), 32'd2);
        chk("b2b_cs_gap", 32'(last_gap), 32'd1);
        repeat (3) @(negedge clk);
        check_idle(8'h34);

        // Reset after the third sclk rise
        d0 = n_done;
        tx_data = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && rises < 3; i++) @(negedge clk);
        chk("rst_reached_rise3", 32'(rises), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_cs_n", 32'(cs_n_m), 32'd1);
        chk("rst_sclk", 32'(sclk_m), 32'd0);
        chk("rst_busy", 32'(busy_m), 32'd0);
        chk("rst_rx", 32'(rx_m), 32'd0);
        chk("rst_done", 32'(done_m), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_txn(8'hC3, 8'hC3, 34);
        wait_empty(300);
        chk("rst_no_stray_done", 32'(n_done - d0), 32'd1);
        repeat (3) @(negedge clk);
        check_idle(8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
